// File: rtl/pool_window_engine_pkg.sv
// Shared definitions for the pooling engine: mode codes, FSM state encoding,
// and accumulator width helpers.
package pool_window_engine_pkg;

    localparam logic POOL_MODE_MAX = 1'b0;
    localparam logic POOL_MODE_AVG = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        EMIT  = 2'd2,
        DONE  = 2'd3
    } pool_state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

    // A full POOL_SIZE x POOL_SIZE sum needs 2*log2(POOL_SIZE) guard bits.
    function automatic int acc_width(input int dwidth, input int pool_size);
        return dwidth + 2 * clog2(pool_size);
    endfunction

endpackage

// File: rtl/pool_lane_reduce.sv
// One output lane of the pooling engine: running signed max or sum over the
// POOL_SIZE input lanes it owns, with clear/load and final average shift.
module pool_lane_reduce
    import pool_window_engine_pkg::*;
#(
    parameter int DWIDTH    = 8,
    parameter int POOL_SIZE = 2,
    parameter int ACC_W     = acc_width(8, 2)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          mode,
    input  logic                          clear,
    input  logic                          load,
    input  logic [POOL_SIZE*DWIDTH-1:0]   elems,
    input  logic [POOL_SIZE-1:0]          mask,
    output logic [DWIDTH-1:0]             result
);

    localparam int SHIFT = 2 * clog2(POOL_SIZE);
    localparam logic signed [ACC_W-1:0] MIN_VAL =
        {{(ACC_W - DWIDTH + 1){1'b1}}, {(DWIDTH - 1){1'b0}}};

    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  init;
    logic signed [ACC_W-1:0]  base;
    logic signed [ACC_W-1:0]  folded;
    logic signed [ACC_W-1:0]  elem;
    logic signed [DWIDTH-1:0] v;

    // Masked lanes contribute the identity of the current reduction, which is
    // also the value a freshly cleared accumulator starts from.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        init   = (mode == POOL_MODE_AVG) ? '0 : MIN_VAL;
        base   = clear ? init : acc;
        folded = base;
        elem   = '0;
        v      = '0;
        for (int i = 0; i < POOL_SIZE; i++) begin
            v    = elems[i*DWIDTH +: DWIDTH];
            elem = mask[i] ? ACC_W'(v) : init;
            if (mode == POOL_MODE_AVG) folded = folded + elem;
            else if (elem > folded)    folded = elem;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state updates use non-blocking assignments so all flops sample together.
        if (!reset)              acc <= '0;
        else if (clear || load)  acc <= load ? folded : base;
    end

    assign result = (mode == POOL_MODE_AVG) ? DWIDTH'(acc >>> SHIFT) : DWIDTH'(acc);

endmodule

// File: rtl/pool_window_engine.sv
// Max/average pooling stage with registered bypass. Define POOL_RELU_EN to
// clamp pooled (non-bypass) results to zero or above.
module pool_window_engine
    import pool_window_engine_pkg::*;
#(
    parameter int DWIDTH     = 8,
    parameter int NUM_LANES  = 4,
    parameter int POOL_SIZE  = 2,
    parameter int MASK_WIDTH = NUM_LANES,
    parameter int CNT_W      = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable_pool,
    input  logic                          pool_mode,
    input  logic                          start_pool,
    input  logic [CNT_W-1:0]              num_windows,
    input  logic                          in_data_available,
    input  logic [NUM_LANES*DWIDTH-1:0]   inp_data,
    input  logic [MASK_WIDTH-1:0]         validity_mask,
    output logic [NUM_LANES*DWIDTH-1:0]   out_data,
    output logic                          out_data_available,
    output logic                          done_pool
);

    localparam int OUT_LANES = NUM_LANES / POOL_SIZE;
    localparam int ACC_W     = acc_width(DWIDTH, POOL_SIZE);
    localparam int ROW_W     = (POOL_SIZE > 1) ? clog2(POOL_SIZE) : 1;

    pool_state_t              state, state_next;
    logic                     mode_q;
    logic [CNT_W-1:0]         num_q;
    logic [CNT_W-1:0]         win_cnt;
    logic [ROW_W-1:0]         row_cnt;
    logic                     start_ok, last_win, last_row, fold, clear, mode_eff, bypass;
    logic [DWIDTH-1:0]        lane_res [OUT_LANES];
    logic [DWIDTH-1:0]        lane_val;
    logic [NUM_LANES*DWIDTH-1:0] pooled;

    assign start_ok = (state == IDLE) && start_pool && enable_pool;
    assign last_win = (CNT_W'(win_cnt + 1'b1) == num_q);
    assign last_row = (row_cnt == ROW_W'(POOL_SIZE - 1));
    // A vector arriving during the final EMIT belongs to no window and is dropped.
    assign fold     = in_data_available &&
                      ((state == ACCUM) || ((state == EMIT) && !last_win));
    assign clear    = start_ok || (state == EMIT);
    assign mode_eff = (state == IDLE) ? pool_mode : mode_q;
    assign bypass   = ((state == IDLE) || (state == DONE)) && !enable_pool;
    assign done_pool = (state == IDLE) || (state == DONE);

    for (genvar j = 0; j < OUT_LANES; j++) begin : g_lane
        pool_lane_reduce #(
            .DWIDTH    (DWIDTH),
            .POOL_SIZE (POOL_SIZE),
            .ACC_W     (ACC_W)
        ) u_reduce (
            .clk    (clk),
            .reset  (reset),
            .mode   (mode_eff),
            .clear  (clear),
            .load   (fold),
            .elems  (inp_data[j*POOL_SIZE*DWIDTH +: POOL_SIZE*DWIDTH]),
            .mask   (validity_mask[j*POOL_SIZE +: POOL_SIZE]),
            .result (lane_res[j])
        );
    end

    always_comb begin
        pooled   = '0;
        lane_val = '0;
        for (int j = 0; j < OUT_LANES; j++) begin
            lane_val = lane_res[j];
`ifdef POOL_RELU_EN
            if (lane_val[DWIDTH-1]) lane_val = '0;
`endif
            pooled[j*DWIDTH +: DWIDTH] = lane_val;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_ok) state_next = (num_windows == '0) ? DONE : ACCUM;
            ACCUM:   if (fold && last_row) state_next = EMIT;
            EMIT: begin
                if (last_win)              state_next = DONE;
                else if (fold && last_row) state_next = EMIT;
                else                       state_next = ACCUM;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state              <= IDLE;
            mode_q             <= POOL_MODE_MAX;
            num_q              <= '0;
            win_cnt            <= '0;
            row_cnt            <= '0;
            out_data           <= '0;
            out_data_available <= 1'b0;
        end else begin
            state              <= state_next;
            out_data_available <= 1'b0;
            if (start_ok) begin
                mode_q  <= pool_mode;
                num_q   <= num_windows;
                win_cnt <= '0;
                row_cnt <= '0;
            end
            if (fold) row_cnt <= last_row ? '0 : row_cnt + 1'b1;
            if (state == EMIT) begin
                out_data           <= pooled;
                out_data_available <= 1'b1;
                win_cnt            <= win_cnt + 1'b1;
            end else if (bypass) begin
                out_data           <= inp_data;
                out_data_available <= in_data_available;
            end
        end
    end

endmodule
